// File: rtl/lc3_decode_stage_if.sv
// rtl/lc3_decode_stage_if.sv - decode stage bus: fetch-side capture inputs and decode_out fields (LC3_DECODE_ILLEGAL_CNT_EN adds illegal_cnt)
interface lc3_decode_stage_if;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic [5:0]  E_Control;
`ifdef LC3_DECODE_ILLEGAL_CNT_EN
    logic [7:0]  illegal_cnt;

    modport master (
        input  enable_decode, dout, npc_in,
        output IR, npc_out, W_Control, Mem_Control, E_Control, illegal_cnt
    );
    modport slave (
        output enable_decode, dout, npc_in,
        input  IR, npc_out, W_Control, Mem_Control, E_Control, illegal_cnt
    );
`else
    modport master (
        input  enable_decode, dout, npc_in,
        output IR, npc_out, W_Control, Mem_Control, E_Control
    );
    modport slave (
        output enable_decode, dout, npc_in,
        input  IR, npc_out, W_Control, Mem_Control, E_Control
    );
`endif
endinterface

// File: rtl/lc3_decode_stage.sv
// rtl/lc3_decode_stage.sv - LC3 decode stage: registers IR/npc and W/Mem/E controls
// Optional illegal-opcode counter enabled by LC3_DECODE_ILLEGAL_CNT_EN.
module lc3_decode_stage (
    input  logic                 clock,
    input  logic                 reset,
    lc3_decode_stage_if.master   bus
);

    logic [1:0] w_next;
    logic       mem_next;
    logic [5:0] e_next;
    logic       illegal_op;

    // E field layout: {alu[1:0], pcselect1[1:0], pcselect2, op2select}
    always_comb begin
        w_next     = 2'd0;
        mem_next   = 1'b0;
        e_next     = 6'd0;
        illegal_op = 1'b0;
        case (bus.dout[15:12])
            4'b0001: e_next = {2'b00, 2'b00, 1'b0, ~bus.dout[5]};
            4'b0101: e_next = {2'b01, 2'b00, 1'b0, ~bus.dout[5]};
            4'b1001: e_next = {2'b10, 2'b00, 1'b0, 1'b0};
            4'b0000: e_next = {2'b00, 2'b01, 1'b1, 1'b0};
            4'b1100: e_next = {2'b00, 2'b11, 1'b0, 1'b0};
            4'b0010: begin
                e_next = {2'b00, 2'b01, 1'b1, 1'b0};
                w_next = 2'd1;
            end
            4'b0110: begin
                e_next = {2'b00, 2'b10, 1'b0, 1'b0};
                w_next = 2'd1;
            end
            4'b1010: begin
                e_next   = {2'b00, 2'b01, 1'b1, 1'b0};
                w_next   = 2'd1;
                mem_next = 1'b1;
            end
            4'b1110: begin
                e_next = {2'b00, 2'b01, 1'b1, 1'b0};
                w_next = 2'd2;
            end
            4'b0011: e_next = {2'b00, 2'b01, 1'b1, 1'b0};
            4'b0111: e_next = {2'b00, 2'b10, 1'b0, 1'b0};
            4'b1011: begin
                e_next   = {2'b00, 2'b01, 1'b1, 1'b0};
                mem_next = 1'b1;
            end
            default: illegal_op = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.IR          <= 16'd0;
            bus.npc_out     <= 16'd0;
            bus.W_Control   <= 2'd0;
            bus.Mem_Control <= 1'b0;
            bus.E_Control   <= 6'd0;
        end else if (bus.enable_decode) begin
            bus.IR          <= bus.dout;
            bus.npc_out     <= bus.npc_in;
            bus.W_Control   <= w_next;
            bus.Mem_Control <= mem_next;
            bus.E_Control   <= e_next;
        end
    end

`ifdef LC3_DECODE_ILLEGAL_CNT_EN
    // Saturating: a stuck stream of bad opcodes must not wrap back to a small count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.illegal_cnt <= 8'd0;
        end else if (bus.enable_decode && illegal_op && (bus.illegal_cnt != 8'hFF)) begin
            bus.illegal_cnt <= bus.illegal_cnt + 8'd1;
        end
    end
`else
    logic unused_illegal;
    assign unused_illegal = illegal_op;
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// tb/tb_lc3_decode_stage.sv - scoreboard bench for lc3_decode_stage against a table-driven decode model
module tb_lc3_decode_stage;

    logic clock = 1'b0;
    logic reset = 1'b1;

    lc3_decode_stage_if bus ();

    lc3_decode_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [1:0]  w;
        logic        mem;
        logic [5:0]  e;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int checks = 0;
    int passed = 0;

    // Reference decode table, one row per opcode
    int alu_t [16];
    int ps1_t [16];
    int ps2_t [16];
    int w_t   [16];
    int mem_t [16];
    int op2_t [16];
    int ill_t [16];

    task automatic set_row(input int op, input int alu, input int ps1, input int ps2,
                           input int w, input int mem, input int op2);
        alu_t[op] = alu; ps1_t[op] = ps1; ps2_t[op] = ps2;
        w_t[op] = w; mem_t[op] = mem; op2_t[op] = op2; ill_t[op] = 0;
    endtask

    task automatic init_table();
        for (int i = 0; i < 16; i++) begin
            alu_t[i] = 0; ps1_t[i] = 0; ps2_t[i] = 0;
            w_t[i] = 0; mem_t[i] = 0; op2_t[i] = 0; ill_t[i] = 1;
        end
        set_row(4'b0001, 0, 0, 0, 0, 0, 1);
        set_row(4'b0101, 1, 0, 0, 0, 0, 1);
        set_row(4'b1001, 2, 0, 0, 0, 0, 0);
        set_row(4'b0000, 0, 1, 1, 0, 0, 0);
        set_row(4'b1100, 0, 3, 0, 0, 0, 0);
        set_row(4'b0010, 0, 1, 1, 1, 0, 0);
        set_row(4'b0110, 0, 2, 0, 1, 0, 0);
        set_row(4'b1010, 0, 1, 1, 1, 1, 0);
        set_row(4'b1110, 0, 1, 1, 2, 0, 0);
        set_row(4'b0011, 0, 1, 1, 0, 0, 0);
        set_row(4'b0111, 0, 2, 0, 0, 0, 0);
        set_row(4'b1011, 0, 1, 1, 0, 1, 0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    task automatic step(input logic r, input logic en, input logic [15:0] d, input logic [15:0] n);
        int op;
        int op2;
        @(negedge clock);
        reset = r;
        bus.enable_decode = en;
        bus.dout = d;
        bus.npc_in = n;
        if (r) begin
            cur = '{default: '0};
        end else if (en) begin
            op = int'(d[15:12]);
            op2 = (op2_t[op] != 0 && d[5] == 1'b0) ? 1 : 0;
            cur.ir  = d;
            cur.npc = n;
            cur.w   = 2'(w_t[op]);
            cur.mem = 1'(mem_t[op]);
            cur.e   = 6'(alu_t[op] * 16 + ps1_t[op] * 4 + ps2_t[op] * 2 + op2);
            if (ill_t[op] != 0) cur.cnt = (cur.cnt < 8'd255) ? cur.cnt + 8'd1 : 8'd255;
        end
        exp_q.push_back(cur);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ir"},  32'(bus.IR), 32'd0);
        check({tag, "_npc"}, 32'(bus.npc_out), 32'd0);
        check({tag, "_w"},   32'(bus.W_Control), 32'd0);
        check({tag, "_mem"}, 32'(bus.Mem_Control), 32'd0);
        check({tag, "_e"},   32'(bus.E_Control), 32'd0);
`ifdef LC3_DECODE_ILLEGAL_CNT_EN
        check({tag, "_cnt"}, 32'(bus.illegal_cnt), 32'd0);
`endif
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ir",  32'(bus.IR), 32'(e.ir));
                check("npc", 32'(bus.npc_out), 32'(e.npc));
                check("w",   32'(bus.W_Control), 32'(e.w));
                check("mem", 32'(bus.Mem_Control), 32'(e.mem));
                check("e",   32'(bus.E_Control), 32'(e.e));
`ifdef LC3_DECODE_ILLEGAL_CNT_EN
                check("cnt", 32'(bus.illegal_cnt), 32'(e.cnt));
`endif
            end
        end
    end

    initial begin
        init_table();
        cur = '{default: '0};
        bus.enable_decode = 1'b1;
        bus.dout = 16'h1283;
        bus.npc_in = 16'h3001;
        #2;
        check_all_zero("por");

        step(1'b1, 1'b1, 16'h1283, 16'h3001);
        step(1'b0, 1'b0, 16'h1283, 16'h3001);
        step(1'b0, 1'b1, 16'h1283, 16'h3001);
        step(1'b0, 1'b1, 16'hA805, 16'h3002);
        step(1'b0, 1'b1, 16'hE1FF, 16'h3003);
        step(1'b0, 1'b1, 16'h6A42, 16'h3004);
        repeat (3) step(1'b0, 1'b0, 16'hC1C0, 16'h4000);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                @(posedge clock);
                #3;
                reset = 1'b1;
                #1;
                check_all_zero("async_rst");
                step(1'b1, 1'b1, 16'h1111, 16'h2222);
                step(1'b1, 1'b1, 16'h5555, 16'h6666);
                repeat (2) step(1'b0, 1'b0, 16'h1283, 16'h7777);
            end
            step(1'b0, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
        end

`ifdef LC3_DECODE_ILLEGAL_CNT_EN
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 16'hD000, 16'(i));
        step(1'b0, 1'b0, 16'h4000, 16'h0);
        step(1'b0, 1'b1, 16'hF025, 16'h1);
`endif

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
